// File: rtl/psram_ctrl_if.sv
// Command/response bus between a requester and the PSRAM controller.
// One command in flight at a time; every command gets exactly one response pulse.
interface psram_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [21:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic [1:0]  cmd_wmask;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wmask,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wmask,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );
endinterface

// File: rtl/psram_ctrl.sv
// Single-word HyperBus-style controller for the x8 DDR on-package PSRAM.
// Pin-side outputs are decoded from the state register; DDR primitives live in the top level.
module psram_ctrl #(
    parameter int INIT_CYCLES = 10125,
    parameter int LAT_CYCLES  = 10,
    parameter int RECOVERY    = 3,
    parameter int RD_TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       reset,
    psram_ctrl_if.slave bus,
    output logic       psram_cs_n,
    output logic       psram_ck_en,
    output logic       dq_oe,
    output logic [7:0] dq_out_r,
    output logic [7:0] dq_out_f,
    input  logic [7:0] dq_in_r,
    input  logic [7:0] dq_in_f,
    output logic       rwds_oe,
    output logic       rwds_out_r,
    output logic       rwds_out_f,
    input  logic       rwds_in_r,
    input  logic       rwds_in_f
);
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int PH_MAX = (LAT_CYCLES > RD_TIMEOUT)
                          ? ((LAT_CYCLES > RECOVERY) ? LAT_CYCLES : RECOVERY)
                          : ((RD_TIMEOUT > RECOVERY) ? RD_TIMEOUT : RECOVERY);
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [PH_W-1:0]   LAT_LAST  = PH_W'(LAT_CYCLES - 1);
    localparam logic [PH_W-1:0]   REC_LAST  = PH_W'(RECOVERY - 1);
    localparam logic [PH_W-1:0]   RD_LAST   = PH_W'(RD_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_CA0, S_CA1, S_CA2, S_LAT, S_WR, S_RD, S_REC
    } state_e;

    state_e             state_q, state_d;
    logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
    logic [PH_W-1:0]    cnt_q, cnt_d;
    logic               write_q, write_d;
    logic [21:0]        addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [1:0]         wmask_q, wmask_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               init_done_q, init_done_d;
    logic [47:0]        ca;

    // Linear-burst memory-space command/address word.
    assign ca = {~write_q, 1'b0, 1'b1, 10'b0, addr_q[21:3], 13'b0, addr_q[2:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        cnt_d         = cnt_q;
        write_d       = write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        init_done_d   = init_done_q;
        psram_cs_n    = 1'b1;
        psram_ck_en   = 1'b0;
        dq_oe         = 1'b0;
        dq_out_r      = 8'h00;
        dq_out_f      = 8'h00;
        rwds_oe       = 1'b0;
        rwds_out_r    = 1'b0;
        rwds_out_f    = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;

        case (state_q)
            S_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    init_done_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    write_d = bus.cmd_write;
                    addr_d  = bus.cmd_addr;
                    wdata_d = bus.cmd_wdata;
                    wmask_d = bus.cmd_wmask;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = S_CA0;
                end
            end
            S_CA0, S_CA1, S_CA2: begin
                psram_cs_n  = 1'b0;
                psram_ck_en = 1'b1;
                dq_oe       = 1'b1;
                if (state_q == S_CA0) begin
                    dq_out_r = ca[47:40];
                    dq_out_f = ca[39:32];
                    state_d  = S_CA1;
                end else if (state_q == S_CA1) begin
                    dq_out_r = ca[31:24];
                    dq_out_f = ca[23:16];
                    state_d  = S_CA2;
                end else begin
                    dq_out_r = ca[15:8];
                    dq_out_f = ca[7:0];
                    cnt_d    = '0;
                    state_d  = S_LAT;
                end
            end
            S_LAT: begin
                psram_cs_n  = 1'b0;
                psram_ck_en = 1'b1;
                if (cnt_q == LAT_LAST) begin
                    cnt_d   = '0;
                    state_d = write_q ? S_WR : S_RD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WR: begin
                psram_cs_n  = 1'b0;
                psram_ck_en = 1'b1;
                dq_oe       = 1'b1;
                rwds_oe     = 1'b1;
                dq_out_r    = wdata_q[15:8];
                dq_out_f    = wdata_q[7:0];
                // RWDS high masks the byte, so it is the inverse of the enable.
                rwds_out_r  = ~wmask_q[1];
                rwds_out_f  = ~wmask_q[0];
                cnt_d       = '0;
                state_d     = S_REC;
            end
            S_RD: begin
                psram_cs_n  = 1'b0;
                psram_ck_en = 1'b1;
                // Data beat check comes first so a strobe in the final cycle still wins.
                if (rwds_in_r && !rwds_in_f) begin
                    rdata_d = {dq_in_r, dq_in_f};
                    cnt_d   = '0;
                    state_d = S_REC;
                end else if (cnt_q == RD_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    cnt_d   = '0;
                    state_d = S_REC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REC: begin
                bus.rsp_valid = (cnt_q == '0);
                if (cnt_q == REC_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = bus.rsp_valid & err_q;
    assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_psram_ctrl.sv
// Directed bench for psram_ctrl: init wait, CA encoding, write/read timing, timeout, reset abort.
module tb_psram_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       psram_cs_n, psram_ck_en, dq_oe, rwds_oe, rwds_out_r, rwds_out_f;
    logic [7:0] dq_out_r, dq_out_f, dq_in_r, dq_in_f;
    logic       rwds_in_r, rwds_in_f;
    int         n_assert = 0;
    int         n_fail   = 0;

    psram_ctrl_if bus ();

    psram_ctrl #(.INIT_CYCLES(20), .LAT_CYCLES(10), .RECOVERY(3), .RD_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .psram_cs_n(psram_cs_n), .psram_ck_en(psram_ck_en),
        .dq_oe(dq_oe), .dq_out_r(dq_out_r), .dq_out_f(dq_out_f),
        .dq_in_r(dq_in_r), .dq_in_f(dq_in_f),
        .rwds_oe(rwds_oe), .rwds_out_r(rwds_out_r), .rwds_out_f(rwds_out_f),
        .rwds_in_r(rwds_in_r), .rwds_in_f(rwds_in_f)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge while idle; returns at the negedge of cycle T+1.
    task automatic issue(input logic w, input logic [21:0] a, input logic [15:0] d,
                         input logic [1:0] m);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_wmask = m;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_wdata = 16'hFFFF;
    endtask

    task automatic wait_ready(input string tag);
        int i;
        for (i = 0; i < 60 && bus.cmd_ready !== 1'b1; i++) @(negedge clk);
        chk(tag, {31'b0, bus.cmd_ready}, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0;   bus.cmd_wmask = '0;
        dq_in_r = '0; dq_in_f = '0; rwds_in_r = 1'b0; rwds_in_f = 1'b0;
        wait_neg(3);

        // Reset state
        chk("rst_cs_n",  {31'b0, psram_cs_n}, 32'd1);
        chk("rst_outs",  {24'b0, psram_ck_en, dq_oe, rwds_oe, bus.cmd_ready,
                          bus.rsp_valid, bus.rsp_err, bus.init_done, rwds_out_r}, 32'd0);
        chk("rst_data",  {bus.rsp_rdata, dq_out_r, dq_out_f}, 32'd0);

        // Init wait: 20 cycles after release
        reset = 1'b0;
        wait_neg(19);
        chk("init_19", {30'b0, bus.init_done, bus.cmd_ready}, 32'd0);
        wait_neg(1);
        chk("init_20", {29'b0, bus.init_done, bus.cmd_ready, psram_cs_n}, 32'h7);

        // Write 0x12345 <- 0xA5C3, both bytes
        issue(1'b1, 22'h12345, 16'hA5C3, 2'b11);                 // T+1
        chk("wr_ca0", {13'b0, psram_cs_n, psram_ck_en, dq_oe, dq_out_r, dq_out_f}, {13'b0, 3'b011, 16'h2000});
        chk("wr_busy", {31'b0, bus.cmd_ready}, 32'd0);
        wait_neg(1); chk("wr_ca1", {dq_out_r, dq_out_f}, 32'h2468);
        wait_neg(1); chk("wr_ca2", {dq_out_r, dq_out_f}, 32'h0005);
        wait_neg(1);                                             // T+4
        chk("wr_lat", {29'b0, psram_cs_n, psram_ck_en, dq_oe}, 32'b010);
        wait_neg(9);                                             // T+13
        chk("wr_lat_end", {30'b0, dq_oe, rwds_oe}, 32'd0);
        wait_neg(1);                                             // T+14
        chk("wr_data", {dq_oe, rwds_oe, rwds_out_r, rwds_out_f, dq_out_r, dq_out_f},
            {1'b1, 1'b1, 1'b0, 1'b0, 16'hA5C3});
        chk("wr_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
        wait_neg(1);                                             // T+15
        chk("wr_rsp", {bus.rsp_valid, bus.rsp_err, psram_cs_n, psram_ck_en, bus.rsp_rdata},
            {4'b1010, 16'h0000});
        wait_neg(1); chk("wr_rsp_pulse", {31'b0, bus.rsp_valid}, 32'd0);
        wait_neg(1); chk("wr_rec_T17", {31'b0, bus.cmd_ready}, 32'd0);
        wait_neg(1); chk("wr_ready_T18", {31'b0, bus.cmd_ready}, 32'd1);

        // Write with mask 01: only the low byte enabled
        issue(1'b1, 22'h0, 16'h1234, 2'b01);
        wait_neg(13);                                            // T+14
        chk("wm_data", {rwds_oe, rwds_out_r, rwds_out_f, dq_out_r, dq_out_f},
            {1'b1, 1'b1, 1'b0, 16'h1234});
        wait_ready("wm_ready");

        // Read 0x12345, strobe on 5th RD_WAIT cycle; a 1/1 strobe earlier is not a beat
        issue(1'b0, 22'h12345, 16'h0, 2'b00);                    // T+1
        chk("rd_ca0", {dq_out_r, dq_out_f}, 32'hA000);
        wait_neg(15);                                            // T+16
        rwds_in_r = 1'b1; rwds_in_f = 1'b1; dq_in_r = 8'h11; dq_in_f = 8'h22;
        wait_neg(1);                                             // T+17
        rwds_in_r = 1'b0; rwds_in_f = 1'b0;
        chk("rd_still_wait", {30'b0, psram_cs_n, bus.rsp_valid}, 32'd0);
        wait_neg(1);                                             // T+18
        rwds_in_r = 1'b1; rwds_in_f = 1'b0; dq_in_r = 8'hBE; dq_in_f = 8'hEF;
        wait_neg(1);                                             // T+19
        rwds_in_r = 1'b0; dq_in_r = 8'h00; dq_in_f = 8'h00;
        chk("rd_rsp", {bus.rsp_valid, bus.rsp_err, psram_cs_n, 13'b0, bus.rsp_rdata},
            {3'b101, 13'b0, 16'hBEEF});
        wait_ready("rd_ready");

        // Read timeout: no strobe for 16 RD_WAIT cycles
        issue(1'b0, 22'h40, 16'h0, 2'b00);                       // T+1
        wait_neg(28);                                            // T+29
        chk("to_last_wait", {30'b0, psram_cs_n, bus.rsp_valid}, 32'd0);
        wait_neg(1);                                             // T+30
        chk("to_rsp", {bus.rsp_valid, bus.rsp_err, psram_cs_n, 13'b0, bus.rsp_rdata},
            {3'b111, 13'b0, 16'h0000});
        wait_neg(1);
        chk("to_err_drop", {30'b0, bus.rsp_valid, bus.rsp_err}, 32'd0);
        wait_ready("to_ready");

        // Strobe in the last allowed RD_WAIT cycle still delivers data
        issue(1'b0, 22'h41, 16'h0, 2'b00);
        wait_neg(28);                                            // T+29
        rwds_in_r = 1'b1; rwds_in_f = 1'b0; dq_in_r = 8'h5A; dq_in_f = 8'h69;
        wait_neg(1);                                             // T+30
        rwds_in_r = 1'b0;
        chk("late_rsp", {bus.rsp_valid, bus.rsp_err, 14'b0, bus.rsp_rdata},
            {2'b10, 14'b0, 16'h5A69});
        wait_ready("late_ready");

        // Reset during LAT aborts the transaction and restarts the init wait
        issue(1'b1, 22'h3, 16'hCAFE, 2'b11);                     // T+1
        wait_neg(5);                                             // T+6
        reset = 1'b1;
        wait_neg(1);                                             // T+7
        chk("abort", {27'b0, psram_cs_n, psram_ck_en, dq_oe, rwds_oe, bus.init_done},
            32'b10000);
        reset = 1'b0;
        wait_neg(19);
        chk("reinit_19", {31'b0, bus.init_done}, 32'd0);
        wait_neg(1);
        chk("reinit_20", {30'b0, bus.init_done, bus.cmd_ready}, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
